// File: rtl/br_pkg.sv
// Shared types and constants for the branch resolution controller and its predictor.
package br_pkg;

    localparam int unsigned DefaultXlen = 32;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StResp
    } state_e;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef logic [1:0] ctr_t;
    localparam ctr_t CtrReset = 2'b01;

    // Saturating 2-bit counter step.
    function automatic ctr_t ctr_next(ctr_t c, logic taken);
        if (taken) begin
            return (c == 2'b11) ? c : c + 2'd1;
        end
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Execute-stage control-transfer op handshake into the branch resolution controller.
interface branch_resolve_ctrl_if #(
    parameter int unsigned XLEN = br_pkg::DefaultXlen
);
    logic            ex_valid;
    logic            ex_ready;
    logic            ex_is_br;
    logic            ex_is_jal;
    logic            ex_is_jalr;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic            ex_pred_taken;

    modport master (
        output ex_valid, ex_is_br, ex_is_jal, ex_is_jalr, ex_funct3,
        output ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred_taken,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_is_br, ex_is_jal, ex_is_jalr, ex_funct3,
        input  ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred_taken,
        output ex_ready
    );
endinterface

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: combinational read, one synchronous write.
module bht_2bit
    import br_pkg::*;
#(
    parameter  int unsigned ENTRIES = 16,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    ctr_t ctr_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= CtrReset;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
        end
    end

    assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves conditional branches, JAL and JALR against the fetch prediction and owns the BHT.
module branch_resolve_ctrl
    import br_pkg::*;
#(
    parameter int unsigned XLEN        = DefaultXlen,
    parameter int unsigned BHT_ENTRIES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [XLEN-1:0]      if_pc,
    output logic                 if_pred_taken,
    branch_resolve_ctrl_if.slave ex,
    output logic [2:0]           br_ctrl,
    output logic [XLEN-1:0]      cmp_a,
    output logic [XLEN-1:0]      cmp_b,
    input  logic                 br_out,
    output logic                 res_valid,
    output logic                 res_taken,
    output logic                 redirect,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 illegal_br,
    output logic                 misalign_exc
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    state_e state_q, state_d;

    logic            is_br_q, is_jal_q, is_jalr_q, pred_q;
    logic [XLEN-1:0] pc_q, imm_q;

    logic            res_valid_q, res_taken_q, redirect_q, illegal_q, misalign_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic            accept, in_eval;
    logic            illegal, taken, mispred, misalign;
    logic [XLEN-1:0] target, pc_plus4;

    assign ex.ex_ready = (state_q == StIdle) || (state_q == StResp && !redirect_q);
    assign accept      = ex.ex_valid && ex.ex_ready;
    assign in_eval     = (state_q == StEval);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StEval;
            StEval:  state_d = StResp;
            StResp:  state_d = accept ? StEval : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // br_ctrl/cmp_a/cmp_b double as the captured funct3/rs1/rs2 op registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_br_q   <= 1'b0;
            is_jal_q  <= 1'b0;
            is_jalr_q <= 1'b0;
            pred_q    <= 1'b0;
            pc_q      <= '0;
            imm_q     <= '0;
            br_ctrl   <= '0;
            cmp_a     <= '0;
            cmp_b     <= '0;
        end else if (accept) begin
            is_br_q   <= ex.ex_is_br;
            is_jal_q  <= ex.ex_is_jal;
            is_jalr_q <= ex.ex_is_jalr;
            pred_q    <= ex.ex_pred_taken;
            pc_q      <= ex.ex_pc;
            imm_q     <= ex.ex_imm;
            br_ctrl   <= ex.ex_funct3;
            cmp_a     <= ex.ex_rs1;
            cmp_b     <= ex.ex_rs2;
        end
    end

    always_comb begin
        illegal   = is_br_q && (br_ctrl == 3'b010 || br_ctrl == 3'b011);
        taken     = is_br_q ? (br_out && !illegal) : 1'b1;
        target    = (is_jalr_q ? cmp_a : pc_q) + imm_q;
        target[0] = target[0] & ~is_jalr_q;
        pc_plus4  = pc_q + XLEN'(4);
        misalign  = taken && (target[1:0] != 2'b00);
        if (is_br_q) begin
            mispred = (taken != pred_q);
        end else if (is_jal_q) begin
            mispred = !pred_q;
        end else begin
            mispred = 1'b1;
        end
    end

    // Results are registered so they appear for exactly the RESP cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_q   <= 1'b0;
            res_taken_q   <= 1'b0;
            redirect_q    <= 1'b0;
            illegal_q     <= 1'b0;
            misalign_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            res_valid_q   <= in_eval;
            res_taken_q   <= in_eval && taken;
            redirect_q    <= in_eval && mispred && !misalign;
            illegal_q     <= in_eval && illegal;
            misalign_q    <= in_eval && misalign;
            redirect_pc_q <= in_eval ? (taken ? target : pc_plus4) : '0;
        end
    end

    assign res_valid    = res_valid_q;
    assign res_taken    = res_taken_q;
    assign redirect     = redirect_q;
    assign redirect_pc  = redirect_pc_q;
    assign illegal_br   = illegal_q;
    assign misalign_exc = misalign_q;

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_taken (if_pred_taken),
        .wr_en    (in_eval && is_br_q && !illegal),
        .wr_idx   (pc_q[IDX_W+1:2]),
        .wr_taken (taken)
    );

    logic unused_if_pc;
    assign unused_if_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed and randomized checks of branch_resolve_ctrl against a behavioural reference model.
module tb_branch_resolve_ctrl;

    typedef struct packed {
        logic        taken;
        logic        redirect;
        logic        illegal;
        logic        misal;
        logic [31:0] rpc;
    } exp_t;

    localparam logic [1:0] CBR  = 2'd0;
    localparam logic [1:0] CJAL = 2'd1;
    localparam logic [1:0] CJR  = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [2:0]  br_ctrl;
    logic [31:0] cmp_a, cmp_b, redirect_pc;
    logic        br_out, res_valid, res_taken, redirect, illegal_br, misalign_exc;

    int nvec = 0;
    int nerr = 0;
    logic [1:0] bht [16];

    branch_resolve_ctrl_if bus ();

    branch_resolve_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex            (bus),
        .br_ctrl       (br_ctrl),
        .cmp_a         (cmp_a),
        .cmp_b         (cmp_b),
        .br_out        (br_out),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .illegal_br    (illegal_br),
        .misalign_exc  (misalign_exc)
    );

    always #5 clk = ~clk;

    // External comparator; undefined encodings answer 1 so an illegal funct3 cannot look not-taken.
    always_comb begin
        case (br_ctrl)
            3'b000:  br_out = (cmp_a == cmp_b);
            3'b001:  br_out = (cmp_a != cmp_b);
            3'b100:  br_out = ($signed(cmp_a) < $signed(cmp_b));
            3'b101:  br_out = ($signed(cmp_a) >= $signed(cmp_b));
            3'b110:  br_out = (cmp_a < cmp_b);
            3'b111:  br_out = (cmp_a >= cmp_b);
            default: br_out = 1'b1;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_resolve(input logic [1:0] cls, input logic [2:0] f3,
                                         input logic [31:0] pc, input logic [31:0] imm,
                                         input logic [31:0] rs1, input logic [31:0] rs2,
                                         input logic pred);
        exp_t e;
        logic [31:0] tgt;
        logic mis;
        e = '0;
        e.illegal = (cls == CBR) && (f3 == 3'b010 || f3 == 3'b011);
        if (cls != CBR) begin
            e.taken = 1'b1;
        end else if (!e.illegal) begin
            case (f3)
                3'd0: e.taken = (rs1 == rs2);
                3'd1: e.taken = (rs1 != rs2);
                3'd4: e.taken = ($signed(rs1) < $signed(rs2));
                3'd5: e.taken = ($signed(rs1) >= $signed(rs2));
                3'd6: e.taken = (rs1 < rs2);
                default: e.taken = (rs1 >= rs2);
            endcase
        end
        tgt = (cls == CJR) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        e.misal = e.taken && (tgt[1:0] != 2'b00);
        if (cls == CBR) mis = (e.taken != pred);
        else if (cls == CJAL) mis = !pred;
        else mis = 1'b1;
        e.redirect = mis && !e.misal;
        e.rpc = e.taken ? tgt : (pc + 32'd4);
        return e;
    endfunction

    task automatic bht_update(input logic [1:0] cls, input logic [2:0] f3,
                              input logic [31:0] pc, input logic taken);
        int idx, c;
        if (cls != CBR || f3 == 3'b010 || f3 == 3'b011) return;
        idx = int'(pc[5:2]);
        c = int'(bht[idx]);
        c = taken ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
        bht[idx] = 2'(c);
    endtask

    task automatic set_op(input logic [1:0] cls, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic pred);
        bus.ex_is_br      = (cls == CBR);
        bus.ex_is_jal     = (cls == CJAL);
        bus.ex_is_jalr    = (cls == CJR);
        bus.ex_funct3     = f3;
        bus.ex_pc         = pc;
        bus.ex_imm        = imm;
        bus.ex_rs1        = rs1;
        bus.ex_rs2        = rs2;
        bus.ex_pred_taken = pred;
    endtask

    task automatic check_resp(input string tag, input exp_t e);
        check({tag, ".valid"}, 32'(res_valid), 32'd1);
        check({tag, ".taken"}, 32'(res_taken), 32'(e.taken));
        check({tag, ".redirect"}, 32'(redirect), 32'(e.redirect));
        check({tag, ".rpc"}, redirect_pc, e.rpc);
        check({tag, ".illegal"}, 32'(illegal_br), 32'(e.illegal));
        check({tag, ".misal"}, 32'(misalign_exc), 32'(e.misal));
        check({tag, ".ready"}, 32'(bus.ex_ready), 32'(!e.redirect));
    endtask

    // Single op from IDLE: accept, EVAL, RESP, back to IDLE; called and returns at a negedge.
    task automatic do_op(input string tag, input logic [1:0] cls, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic pred);
        exp_t e;
        int idx;
        idx = int'(pc[5:2]);
        e = ref_resolve(cls, f3, pc, imm, rs1, rs2, pred);
        set_op(cls, f3, pc, imm, rs1, rs2, pred);
        bus.ex_valid = 1'b1;
        if_pc = pc;
        #1;
        check({tag, ".rdy_idle"}, 32'(bus.ex_ready), 32'd1);
        check({tag, ".pred_pre"}, 32'(if_pred_taken), 32'(bht[idx][1]));
        @(posedge clk);
        #1 bus.ex_valid = 1'b0;
        @(negedge clk);
        check({tag, ".eval_valid"}, 32'(res_valid), 32'd0);
        check({tag, ".br_ctrl"}, 32'(br_ctrl), 32'(f3));
        check({tag, ".cmp_a"}, cmp_a, rs1);
        check({tag, ".cmp_b"}, cmp_b, rs2);
        check({tag, ".pred_eval"}, 32'(if_pred_taken), 32'(bht[idx][1]));
        @(negedge clk);
        check_resp(tag, e);
        bht_update(cls, f3, pc, e.taken);
        @(negedge clk);
        check({tag, ".idle_valid"}, 32'(res_valid), 32'd0);
        check({tag, ".pred_post"}, 32'(if_pred_taken), 32'(bht[idx][1]));
    endtask

    initial begin
        exp_t e1, e2;
        logic [1:0]  rcls;
        logic [2:0]  rf3;
        logic [31:0] rpc, rimm, rrs1, rrs2;
        logic        rpred;

        rst_n = 1'b0;
        if_pc = '0;
        bus.ex_valid = 1'b0;
        set_op(CBR, 3'd0, '0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 16; i++) bht[i] = 2'b01;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst.ready", 32'(bus.ex_ready), 32'd1);
        check("rst.valid", 32'(res_valid), 32'd0);
        check("rst.redirect", 32'(redirect), 32'd0);
        check("rst.rpc", redirect_pc, 32'd0);
        check("rst.br_ctrl", 32'(br_ctrl), 32'd0);

        do_op("beq", CBR, 3'b000, 32'h100, 32'h20, 32'h5, 32'h5, 1'b0);
        do_op("bltu", CBR, 3'b110, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'h1, 1'b0);
        do_op("blt", CBR, 3'b100, 32'h204, 32'h10, 32'hFFFF_FFFF, 32'h1, 1'b1);
        do_op("jalr_mis", CJR, 3'b000, 32'h300, 32'h0, 32'h203, 32'h0, 1'b1);
        do_op("jal_wrap", CJAL, 3'b000, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0, 1'b0);
        do_op("illegal", CBR, 3'b010, 32'h308, 32'h40, 32'h1, 32'h1, 1'b1);

        // Correctly predicted pair with ex_valid held: second op accepted straight from RESP.
        e1 = ref_resolve(CJAL, 3'd0, 32'h400, 32'h100, 32'h0, 32'h0, 1'b1);
        e2 = ref_resolve(CBR, 3'b000, 32'h404, 32'h8, 32'h1, 32'h2, 1'b0);
        set_op(CJAL, 3'd0, 32'h400, 32'h100, 32'h0, 32'h0, 1'b1);
        bus.ex_valid = 1'b1;
        @(posedge clk);
        #1 set_op(CBR, 3'b000, 32'h404, 32'h8, 32'h1, 32'h2, 1'b0);
        @(negedge clk);
        check("b2b.eval_ready", 32'(bus.ex_ready), 32'd0);
        check("b2b.eval_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        check_resp("b2b.op1", e1);
        @(posedge clk);
        #1 bus.ex_valid = 1'b0;
        @(negedge clk);
        check("b2b.t3_valid", 32'(res_valid), 32'd0);
        check("b2b.t3_cmp_b", cmp_b, 32'h2);
        @(negedge clk);
        check_resp("b2b.op2", e2);
        bht_update(CBR, 3'b000, 32'h404, e2.taken);
        @(negedge clk);

        // Mispredicted first op blocks the held follower while redirect is up.
        e1 = ref_resolve(CBR, 3'b001, 32'h500, 32'h40, 32'h1, 32'h2, 1'b0);
        set_op(CBR, 3'b001, 32'h500, 32'h40, 32'h1, 32'h2, 1'b0);
        bus.ex_valid = 1'b1;
        @(posedge clk);
        #1 set_op(CBR, 3'b000, 32'h504, 32'h8, 32'h1, 32'h1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_resp("mp.op1", e1);
        bht_update(CBR, 3'b001, 32'h500, e1.taken);
        bus.ex_valid = 1'b0;
        @(negedge clk);
        check("mp.dropped", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("mp.still_idle", 32'(res_valid), 32'd0);

        // Reset during EVAL drops the op and clears outputs and the BHT.
        set_op(CBR, 3'b101, 32'h600, 32'h10, 32'h7, 32'h3, 1'b0);
        bus.ex_valid = 1'b1;
        @(posedge clk);
        #1 bus.ex_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) bht[i] = 2'b01;
        @(negedge clk);
        check("rstev.valid", 32'(res_valid), 32'd0);
        check("rstev.taken", 32'(res_taken), 32'd0);
        check("rstev.redirect", 32'(redirect), 32'd0);
        check("rstev.misal", 32'(misalign_exc), 32'd0);
        check("rstev.br_ctrl", 32'(br_ctrl), 32'd0);
        check("rstev.cmp_a", cmp_a, 32'd0);
        check("rstev.cmp_b", cmp_b, 32'd0);
        check("rstev.ready", 32'(bus.ex_ready), 32'd1);
        @(negedge clk);
        check("rstev.no_resp", 32'(res_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i) << 2;
            #1 check("rstev.bht", 32'(if_pred_taken), 32'd0);
        end
        @(negedge clk);

        // Taken loop branch at 0x40 using model prediction; counter saturates at 11.
        for (int k = 0; k < 5; k++) begin
            do_op("loop", CBR, 3'b000, 32'h40, 32'h10, 32'h9, 32'h9, bht[0][1]);
        end
        do_op("loop_exit", CBR, 3'b001, 32'h40, 32'h10, 32'h9, 32'h9, bht[0][1]);
        if_pc = 32'h40;
        #1 check("loop.sat", 32'(if_pred_taken), 32'd1);
        @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            rcls  = 2'($urandom_range(0, 2));
            rf3   = 3'($urandom_range(0, 7));
            rpc   = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_003C) : ($urandom & ~32'h3);
            rimm  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            rrs1  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            rrs2  = ($urandom_range(0, 3) == 0) ? rrs1 : $urandom;
            rpred = (rcls == CBR) ? bht[int'(rpc[5:2])][1] : 1'($urandom_range(0, 1));
            do_op("rand", rcls, rf3, rpc, rimm, rrs1, rrs2, rpred);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
